adc_sample_scheduler: RTL and testbench

- Sequences the pot/current ADC acquisition engine: issues periodic conversion starts and waits for completion with a timeout.
- Box-car averages 2^N samples per lane across 4 pot + 4 current lanes, then publishes a coherent averaged set to the register file.
- Sits between the quad-LTC1864 engines and the host register read mux, replacing free-running raw readout with a rate-controlled, averaged, status-reporting path.

---
 rtl/adc_sched_pkg.sv | 22 ++
 rtl/adc_lane_accum.sv | 34 +++
 rtl/adc_sample_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sched_pkg.sv
// Shared constants and types for the ADC sample scheduler.
package adc_sched_pkg;

    localparam int LANE_W    = 16;
    localparam int NUM_LANES = 4;

    // Register map: channel in addr[7:4], offset in addr[3:0].
    localparam logic [3:0] CH_SCHED       = 4'h0;
    localparam logic [3:0] OFF_ADC_DATA   = 4'h0;
    localparam logic [3:0] OFF_SCHED_CFG  = 4'h0;
    localparam logic [3:0] OFF_SCHED_STAT = 4'h1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        START,
        CONV,
        ACCUM,
        PUBLISH
    } sched_state_t;

endpackage

// File: rtl/adc_lane_accum.sv
// One lane: box-car accumulator plus its published (averaged) value.
module adc_lane_accum
    import adc_sched_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              add,
    input  logic              pub,
    input  logic [2:0]        shift,
    input  logic [LANE_W-1:0] din,
    output logic [LANE_W-1:0] dout
);

    logic [ACC_W-1:0] acc;

    // Clear has priority over add; publish snapshots the shifted sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            dout <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (add)
                acc <= acc + ACC_W'(din);
            if (pub)
                dout <= LANE_W'(acc >> shift);
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Rate-controlled, averaged acquisition sequencer for the pot/current ADCs.
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int PERIOD_W     = 16,
    parameter int AVG_MAX_LOG2 = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        adc_start,
    input  logic        adc_done,
    input  logic [63:0] adc_pot,
    input  logic [63:0] adc_cur,
    input  logic [7:0]  reg_addr,
    input  logic        reg_wen,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        sample_valid
);

    localparam int ACC_W = LANE_W + AVG_MAX_LOG2;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int IDX_W = AVG_MAX_LOG2 + 1;

    sched_state_t state, state_nxt;

    logic [PERIOD_W-1:0] period, tmr, wr_period;
    logic [2:0]          avg_log2, wr_avg;
    logic                enable;
    logic [15:0]         set_cnt;
    logic                timeout_flag, overrun_flag;
    logic [TO_W-1:0]     to_cnt;
    logic [IDX_W-1:0]    idx, idx_inc;
    logic                tick, cfg_wr, stat_wr, take, last, timed_out;
    logic                acc_clr, acc_pub;
    logic                unused_wdata;

    logic [NUM_LANES-1:0][LANE_W-1:0] pot_pub, cur_pub;

    function automatic logic [PERIOD_W-1:0] reload(input logic [PERIOD_W-1:0] p);
        return (p == '0) ? PERIOD_W'(1) : p;
    endfunction

    assign cfg_wr    = reg_wen && (reg_addr == {CH_SCHED, OFF_SCHED_CFG});
    assign stat_wr   = reg_wen && (reg_addr == {CH_SCHED, OFF_SCHED_STAT});
    assign wr_period = reg_wdata[16 +: PERIOD_W];
    assign wr_avg    = (reg_wdata[3:1] > 3'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : reg_wdata[3:1];
    assign unused_wdata = ^reg_wdata[15:4];

    assign tick      = enable && (tmr == PERIOD_W'(1));
    assign idx_inc   = idx + IDX_W'(1);
    assign last      = (idx_inc == (IDX_W'(1) << avg_log2));
    assign timed_out = (state == CONV) && !adc_done && (to_cnt == TO_W'(TIMEOUT_CYC));
    // A config write in the done cycle, or a disable, throws the sample away.
    assign take      = (state == CONV) && adc_done && enable && !cfg_wr;
    assign acc_clr   = cfg_wr || timed_out || (state == PUBLISH);

    assign adc_start    = (state == START);
    assign sample_valid = (state == PUBLISH);

    // Configuration, tick timer, timeout counter and sample index.
    always_ff @(posedge clk) begin
        if (reset) begin
            period   <= '0;
            avg_log2 <= '0;
            enable   <= 1'b0;
            tmr      <= PERIOD_W'(1);
            to_cnt   <= '0;
            idx      <= '0;
        end else begin
            if (cfg_wr) begin
                period   <= wr_period;
                avg_log2 <= wr_avg;
                enable   <= reg_wdata[0];
            end
            // A config write restarts the period from the new value.
            if (cfg_wr)
                tmr <= reload(wr_period);
            else if (!enable || tick)
                tmr <= reload(period);
            else
                tmr <= tmr - PERIOD_W'(1);
            // Counts cycles since adc_start; 1 on the first CONV cycle.
            if (state == START)
                to_cnt <= TO_W'(1);
            else if (state == CONV)
                to_cnt <= to_cnt + TO_W'(1);
            if (acc_clr)
                idx <= '0;
            else if (state == ACCUM)
                idx <= idx_inc;
        end
    end

    // Sticky status flags and published-set counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag <= 1'b0;
            overrun_flag <= 1'b0;
            set_cnt      <= '0;
        end else begin
            if (timed_out)
                timeout_flag <= 1'b1;
            else if (stat_wr && reg_wdata[1])
                timeout_flag <= 1'b0;
            if (tick && (state inside {START, CONV, ACCUM, PUBLISH}))
                overrun_flag <= 1'b1;
            else if (stat_wr && reg_wdata[2])
                overrun_flag <= 1'b0;
            // Bumped together with the published values so both read coherently.
            if (acc_pub)
                set_cnt <= set_cnt + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state; publish is issued from ACCUM so values land with sample_valid.
    always_comb begin
        state_nxt = state;
        acc_pub   = 1'b0;
        case (state)
            IDLE:    if (enable) state_nxt = WAIT;
            WAIT:    if (!enable) state_nxt = IDLE;
                     else if (tick) state_nxt = START;
            START:   state_nxt = CONV;
            CONV:    if (take) state_nxt = ACCUM;
                     else if (adc_done || timed_out) state_nxt = enable ? WAIT : IDLE;
            ACCUM:   if (cfg_wr) state_nxt = WAIT;
                     else if (last) begin
                         acc_pub   = 1'b1;
                         state_nxt = PUBLISH;
                     end else state_nxt = WAIT;
            PUBLISH: state_nxt = WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    // Register read mux, zero latency.
    always_comb begin
        reg_rdata = '0;
        if (reg_addr == {CH_SCHED, OFF_SCHED_CFG}) begin
            reg_rdata[16 +: PERIOD_W] = period;
            reg_rdata[3:1]            = avg_log2;
            reg_rdata[0]              = enable;
        end else if (reg_addr == {CH_SCHED, OFF_SCHED_STAT}) begin
            reg_rdata = {set_cnt, 13'd0, overrun_flag, timeout_flag, state != IDLE};
        end else begin
            for (int k = 0; k < NUM_LANES; k++)
                if (reg_addr == {4'(k + 1), OFF_ADC_DATA})
                    reg_rdata = {pot_pub[k], cur_pub[k]};
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        adc_lane_accum #(.ACC_W(ACC_W)) u_pot (
            .clk   (clk),
            .reset (reset),
            .clr   (acc_clr),
            .add   (take),
            .pub   (acc_pub),
            .shift (avg_log2),
            .din   (adc_pot[g*LANE_W +: LANE_W]),
            .dout  (pot_pub[g])
        );
        adc_lane_accum #(.ACC_W(ACC_W)) u_cur (
            .clk   (clk),
            .reset (reset),
            .clr   (acc_clr),
            .add   (take),
            .pub   (acc_pub),
            .shift (avg_log2),
            .din   (adc_cur[g*LANE_W +: LANE_W]),
            .dout  (cur_pub[g])
        );
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Directed bench for adc_sample_scheduler with a simple ADC engine responder.
module tb_adc_sample_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_start, adc_done, sample_valid, reg_wen;
    logic [63:0] adc_pot, adc_cur;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;

    adc_sample_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_pot      (adc_pot),
        .adc_cur      (adc_cur),
        .reg_addr     (reg_addr),
        .reg_wen      (reg_wen),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, start_cnt = 0, sv_cnt = 0, last_start = 0, last_done = 0, last_sv = 0;
    int gap = 0, min_gap = 1000000;
    logic [31:0] rd_at_sv = '0, rd;

    // responder state: tables written by the main process only
    int          resp_lat = 10;
    bit          resp_en  = 1'b0;
    int          pot_lane = 0;
    logic [15:0] pot_tab [8];
    logic [15:0] cur_tab [8];
    int          done_cnt = 0, done_base = 0, ri;

    // ADC engine model: done arrives resp_lat cycles after each start.
    always begin
        @(negedge clk);
        if (adc_start === 1'b1 && resp_en) begin
            repeat (resp_lat) @(negedge clk);
            ri       = (done_cnt - done_base) % 8;
            adc_pot  = 64'(pot_tab[ri]) << (16 * pot_lane);
            adc_cur  = 64'(cur_tab[ri]);
            adc_done = 1'b1;
            done_cnt++;
            @(negedge clk);
            adc_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle, observed just after the falling edge.
    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
        if (adc_start === 1'b1) begin
            if (start_cnt > 0) begin
                gap = cyc - last_start;
                if (gap < min_gap) min_gap = gap;
            end
            last_start = cyc;
            start_cnt++;
        end
        if (adc_done === 1'b1) last_done = cyc;
        if (sample_valid === 1'b1) begin
            sv_cnt++;
            last_sv  = cyc;
            rd_at_sv = reg_rdata;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic clr_counts();
        start_cnt = 0;
        sv_cnt    = 0;
        min_gap   = 1000000;
        done_base = done_cnt;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [31:0] d);
        step();
        reg_addr  = a;
        reg_wdata = d;
        reg_wen   = 1'b1;
        step();
        reg_wen  = 1'b0;
        reg_addr = 8'h10;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [31:0] d);
        reg_addr = a;
        #1;
        d = reg_rdata;
        reg_addr = 8'h10;
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        int b = 0;
        while (start_cnt < n && b < budget) begin
            step();
            b++;
        end
        chk(tag, 32'(start_cnt >= n), 32'd1);
    endtask

    task automatic wait_sv(input string tag, input int n, input int budget);
        int b = 0;
        while (sv_cnt < n && b < budget) begin
            step();
            b++;
        end
        chk(tag, 32'(sv_cnt >= n), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        adc_done  = 1'b0;
        adc_pot   = '0;
        adc_cur   = '0;
        reg_addr  = 8'h10;
        reg_wen   = 1'b0;
        reg_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            pot_tab[i] = 16'h1234;
            cur_tab[i] = 16'hABCD;
        end
        steps(3);
        reset = 1'b0;
        step();
        chk("rst_start", 32'(adc_start), 32'd0);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        reg_read(8'h00, rd); chk("rst_cfg", rd, 32'h0);
        reg_read(8'h01, rd); chk("rst_stat", rd, 32'h0);
        reg_read(8'h10, rd); chk("rst_data", rd, 32'h0);

        // periodic single-sample acquisition
        resp_en = 1'b1;
        clr_counts();
        reg_write(8'h00, 32'h0064_0001);
        wait_sv("tm_sv3", 3, 1000);
        chk("tm_gap", 32'(gap), 32'd100);
        chk("tm_mingap", 32'(min_gap), 32'd100);
        chk("tm_sv_lat", 32'(last_sv - last_done), 32'd2);
        chk("tm_data_at_sv", rd_at_sv, 32'h1234ABCD);
        reg_read(8'h00, rd); chk("tm_cfg", rd, 32'h0064_0001);
        reg_read(8'h01, rd); chk("tm_stat", rd, 32'h0003_0001);
        reg_read(8'h10, rd); chk("tm_data", rd, 32'h1234ABCD);
        reg_read(8'h02, rd); chk("tm_bad_off", rd, 32'h0);
        reg_read(8'h50, rd); chk("tm_bad_ch", rd, 32'h0);
        reg_write(8'h00, 32'h0);
        step();
        reg_read(8'h01, rd); chk("tm_idle_stat", rd, 32'h0003_0000);
        reg_read(8'h10, rd); chk("tm_retained", rd, 32'h1234ABCD);

        // 4-sample average on pot lane 2
        pot_lane   = 1;
        pot_tab[0] = 16'd1; pot_tab[1] = 16'd2; pot_tab[2] = 16'd3; pot_tab[3] = 16'd6;
        for (int i = 0; i < 8; i++) cur_tab[i] = 16'h0;
        clr_counts();
        reg_write(8'h00, 32'h0028_0005);
        wait_starts("av_st4", 4, 400);
        chk("av_no_early_pub", 32'(sv_cnt), 32'd0);
        wait_sv("av_sv1", 1, 100);
        chk("av_one_pub", 32'(sv_cnt), 32'd1);
        reg_read(8'h20, rd); chk("av_pot2", rd, 32'h0003_0000);
        reg_read(8'h01, rd); chk("av_stat", rd, 32'h0004_0001);
        reg_write(8'h00, 32'h0028_000F);
        reg_read(8'h00, rd); chk("av_clamp", rd, 32'h0028_0009);
        reg_write(8'h00, 32'h0);
        steps(30);

        // conversion timeout
        resp_en = 1'b0;
        clr_counts();
        reg_write(8'h00, 32'h0190_0001);
        wait_starts("to_st1", 1, 500);
        steps(200);
        reg_read(8'h01, rd); chk("to_not_yet", rd & 32'h7, 32'h1);
        steps(100);
        reg_read(8'h01, rd); chk("to_flag", rd & 32'h7, 32'h3);
        wait_starts("to_st2", 2, 300);
        chk("to_restart_gap", 32'(min_gap), 32'd400);
        reg_write(8'h01, 32'h2);
        reg_read(8'h01, rd); chk("to_cleared", rd & 32'h7, 32'h1);
        reg_write(8'h00, 32'h0);
        steps(300);
        reg_read(8'h01, rd); chk("to_dis_conv", rd & 32'h7, 32'h2);

        // overrun: period much shorter than a conversion
        resp_en  = 1'b1;
        pot_lane = 0;
        clr_counts();
        reg_write(8'h00, 32'h0003_0001);
        wait_starts("ov_st5", 5, 300);
        chk("ov_gap_min", 32'(min_gap >= 14), 32'd1);
        chk("ov_gap_max", 32'(min_gap <= 16), 32'd1);
        reg_read(8'h01, rd); chk("ov_flag", rd & 32'h4, 32'h4);
        reg_write(8'h00, 32'h0);
        steps(30);
        reg_write(8'h01, 32'h6);
        reg_read(8'h01, rd); chk("ov_cleared", rd & 32'h7, 32'h0);

        // reset in the middle of a conversion
        clr_counts();
        reg_write(8'h00, 32'h0064_0001);
        wait_starts("rc_st1", 1, 200);
        steps(3);
        reset = 1'b1;
        step();
        chk("rc_start", 32'(adc_start), 32'd0);
        reg_read(8'h00, rd); chk("rc_cfg", rd, 32'h0);
        reg_read(8'h01, rd); chk("rc_stat", rd, 32'h0);
        reg_read(8'h10, rd); chk("rc_data", rd, 32'h0);
        reset = 1'b0;
        steps(20);
        chk("rc_late_done_sv", 32'(sv_cnt), 32'd0);
        chk("rc_no_restart", 32'(start_cnt), 32'd1);
        reg_read(8'h01, rd); chk("rc_stat_idle", rd, 32'h0);

        // config write colliding with the 3rd done of a 4-sample set
        pot_tab[0] = 16'd4;  pot_tab[1] = 16'd8;  pot_tab[2] = 16'd1000; pot_tab[3] = 16'd16;
        pot_tab[4] = 16'd20; pot_tab[5] = 16'd24; pot_tab[6] = 16'd28;   pot_tab[7] = 16'd0;
        clr_counts();
        reg_write(8'h00, 32'h0028_0005);
        wait_starts("cw_st3", 3, 300);
        steps(10);
        reg_addr  = 8'h00;
        reg_wdata = 32'h0028_0005;
        reg_wen   = 1'b1;
        step();
        reg_wen  = 1'b0;
        reg_addr = 8'h10;
        chk("cw_done_seen", 32'(done_cnt - done_base), 32'd3);
        wait_starts("cw_st7", 7, 400);
        chk("cw_no_early_pub", 32'(sv_cnt), 32'd0);
        wait_sv("cw_sv1", 1, 100);
        reg_read(8'h10, rd); chk("cw_avg", rd, 32'h0016_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
